muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready on both sides.
// Multiplies use shift-add and divides use restoring division, one bit per BUSY cycle.
// Divide-by-zero and signed overflow skip the iteration and complete one edge after accept.
// Optional build macro MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier
// for MUL/MULH/MULHSU/MULHU. Divide timing is the same in both builds.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Two's-complement negate when en is set (W-bit word).
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
      logic signed [WIDTH-1:0] vs;
      vs = v;
      return en ? -vs : vs;
   endfunction

   // Two's-complement negate when en is set (2W-bit product).
   function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic en);
      logic signed [2*WIDTH-1:0] vs;
      vs = v;
      return en ? -vs : vs;
   endfunction

   // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
   function automatic logic src1_signed(input logic [2:0] f);
      return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
   endfunction

   // rs2 is treated as signed by MULH, DIV and REM.
   function automatic logic src2_signed(input logic [2:0] f);
      return (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
   endfunction

   // Control state
   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   result_q;

   // Operation context captured at accept
   logic [2:0]         op_q;
   logic               sign1;
   logic               sign2;
   logic               special;
   logic [WIDTH-1:0]   oper;    // multiplicand for multiplies, divisor for divides
   logic [2*WIDTH-1:0] acc;     // product {hi,lo} or {remainder,quotient}

   // Accept-side decode
   logic               accept;
   logic               in_sign1;
   logic               in_sign2;
   logic [WIDTH-1:0]   in_mag1;
   logic [WIDTH-1:0]   in_mag2;
   logic               div_zero;
   logic               div_ovf;
   logic               in_special;
   logic               in_short;
   logic [WIDTH-1:0]   special_val;

   // Iteration datapath
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] step_next;
   logic [2*WIDTH-1:0] prod_raw;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   fin;

   assign in_ready  = (state == ST_IDLE) && reset_n;
   assign out_valid = (state == ST_DONE);
   assign result    = result_q;

   // Decode the incoming request: signs, magnitudes and special-case results.
   always_comb begin
      accept      = in_valid && in_ready && !flush;
      in_sign1    = src1_signed(op) && src1[WIDTH-1];
      in_sign2    = src2_signed(op) && src2[WIDTH-1];
      in_mag1     = neg_if(src1, in_sign1);
      in_mag2     = neg_if(src2, in_sign2);
      div_zero    = op[2] && (src2 == '0);
      div_ovf     = op[2] && !op[0] && (src1 == MOST_NEG) && (src2 == '1);
      in_special  = div_zero || div_ovf;
      if (div_zero) begin
         special_val = op[1] ? src1 : '1;
      end else begin
         special_val = op[1] ? '0 : src1;
      end
`ifdef MULDIV_FAST_MUL_EN
      in_short    = in_special || !op[2];
`else
      in_short    = in_special;
`endif
   end

   // One shift-add or restoring-divide step, plus the sign-corrected final word.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, oper};
      mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, oper};
      // A borrow out of the subtraction means the divisor did not fit: restore.
      div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
      step_next = op_q[2] ? div_next : mul_next;
`ifdef MULDIV_FAST_MUL_EN
      prod_raw  = {{WIDTH{1'b0}}, oper} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
      prod_raw  = mul_next;
`endif
      prod_s    = neg2_if(prod_raw, sign1 ^ sign2);
      quo       = neg_if(div_next[WIDTH-1:0], sign1 ^ sign2);
      rem       = neg_if(div_next[2*WIDTH-1:WIDTH], sign1);
      if (special) begin
         fin = acc[WIDTH-1:0];
      end else if (op_q[2]) begin
         fin = op_q[1] ? rem : quo;
      end else if (op_q[1:0] == 2'b00) begin
         fin = prod_s[WIDTH-1:0];
      end else begin
         fin = prod_s[2*WIDTH-1:WIDTH];
      end
   end

   // Operand/accumulator registers: loaded on accept, stepped while BUSY.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q    <= op;
         sign1   <= in_sign1;
         sign2   <= in_sign2;
         special <= in_special;
         oper    <= op[2] ? in_mag2 : in_mag1;
         if (in_special) begin
            acc <= {{WIDTH{1'b0}}, special_val};
         end else if (op[2]) begin
            acc <= {{WIDTH{1'b0}}, in_mag1};
         end else begin
            acc <= {{WIDTH{1'b0}}, in_mag2};
         end
      end else if (state == ST_BUSY) begin
         acc <= step_next;
      end
   end

   // Sequencer: IDLE -> BUSY (count down) -> DONE -> IDLE; flush and reset abort.
   // Short operations spend a single BUSY cycle so they complete one edge after accept.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         result_q <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_BUSY;
                  cnt   <= in_short ? CNT_ONE : CNT_FULL;
               end
            end
            ST_BUSY: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state    <= ST_DONE;
                  result_q <= fin;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, expected words queued at issue,
// a negedge monitor pops and compares on every out_valid && out_ready.
module tb_muldiv_unit;
   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W;
`endif
   localparam int DIV_LAT = W;

   logic         clk       = 1'b0;
   logic         reset_n   = 1'b0;
   logic         in_valid  = 1'b0;
   logic         flush     = 1'b0;
   logic         out_ready = 1'b1;
   logic [2:0]   op        = 3'b000;
   logic [W-1:0] src1      = '0;
   logic [W-1:0] src2      = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] result;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int hs_cnt   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got 0x%08h expected no output", result);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result", result, mon_exp);
         end
      end
   end

   task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e, input bit push,
                        output int acc_cyc);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_bit({name, "_in_ready"}, in_ready, 1'b1);
      op = o; src1 = a; src2 = b; in_valid = 1'b1;
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_cyc  = cyc;
   endtask

   task automatic wait_out(input string name, input int acc_cyc, input int lat);
      int n;
      n = 0;
      @(negedge clk);
      check_bit({name, "_busy_in_ready"}, in_ready, 1'b0);
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_int({name, "_latency"}, cyc - acc_cyc, lat);
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] e, input int lat);
      int acc_cyc;
      issue(name, o, a, b, e, 1'b1, acc_cyc);
      wait_out(name, acc_cyc, lat);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish within budget");
      $fatal(1, "timeout");
   end

   initial begin
      int acc_cyc;
      int hs_before;
      logic [W-1:0] held;

      // Reset state
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_bit("rst_in_ready", in_ready, 1'b0);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check("rst_result", result, '0);
      reset_n = 1'b1;
      @(negedge clk);
      check_bit("post_rst_in_ready", in_ready, 1'b1);

      // Iterative multiply / divide vectors
      run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
      run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
      run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);

      // Special cases complete one edge after accept
      run_op("divu_z", 3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
      run_op("remu_z", 3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1);
      run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // Back-pressure: DONE held while out_ready is low
      out_ready = 1'b0;
      issue("mul_bp", 3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 1'b1, acc_cyc);
      wait_out("mul_bp", acc_cyc, MUL_LAT);
      held = result;
      check("mul_bp_value", held, 32'h242D_2080);
      hs_before = hs_cnt;
      repeat (3) begin
         @(negedge clk);
         check("bp_stable", result, held);
         check_bit("bp_in_ready", in_ready, 1'b0);
         check_bit("bp_out_valid", out_valid, 1'b1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_bit("bp_released", out_valid, 1'b0);
      check_int("bp_handshakes", hs_cnt - hs_before, 1);

      // Flush in the tenth cycle of a DIVU, then an immediate MULHU
      issue("divu_fl", 3'b101, 32'd100, 32'd7, '0, 1'b0, acc_cyc);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_bit("flush_out_valid", out_valid, 1'b0);
      check_bit("flush_idle", in_ready, 1'b1);
      run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, MUL_LAT);

      // Reset for one cycle in the middle of a DIV
      issue("div_rst", 3'b100, 32'd100, 32'd7, '0, 1'b0, acc_cyc);
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check_bit("midrst_out_valid", out_valid, 1'b0);
      check("midrst_result", result, '0);
      check_bit("midrst_in_ready", in_ready, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      check_bit("after_rst_in_ready", in_ready, 1'b1);
      check_bit("after_rst_out_valid", out_valid, 1'b0);
      run_op("div_post", 3'b100, 32'd100, 32'd7, 32'd14, DIV_LAT);

      repeat (5) @(negedge clk);
      check_int("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
